// File: rtl/tlb_ctrl.sv
// tlb_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the TLB ports and returns CSR write-back values
module tlb_ctrl #(
   parameter  int TLBNUM = 16,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [2:0]    op_code,
   input  logic [4:0]    inv_op,
   input  logic [9:0]    inv_asid,
   input  logic [18:0]   inv_vppn,
   input  logic [IW-1:0] csr_index,
   input  logic [5:0]    csr_ps,
   input  logic          csr_ne,
   input  logic [18:0]   csr_vppn,
   input  logic [9:0]    csr_asid,
   input  logic [26:0]   csr_elo0,
   input  logic [26:0]   csr_elo1,
   input  logic          csr_tlbr,
   output logic          done,
   output logic          err,
   output logic          wb_srch,
   output logic          wb_rd,
   output logic [IW-1:0] wb_index,
   output logic          wb_ne,
   output logic [5:0]    wb_ps,
   output logic [18:0]   wb_vppn,
   output logic [9:0]    wb_asid,
   output logic [26:0]   wb_elo0,
   output logic [26:0]   wb_elo1,
   output logic          s1_sel,
   output logic [18:0]   s1_vppn,
   output logic          s1_va_bit12,
   output logic [9:0]    s1_asid,
   input  logic          s1_found,
   input  logic [IW-1:0] s1_index,
   output logic          invtlb_valid,
   output logic [4:0]    invtlb_op,
   output logic          we,
   output logic [IW-1:0] w_index,
   output logic          w_e,
   output logic [18:0]   w_vppn,
   output logic [5:0]    w_ps,
   output logic [9:0]    w_asid,
   output logic          w_g,
   output logic [26:0]   w_lo0,
   output logic [26:0]   w_lo1,
   output logic [IW-1:0] r_index,
   input  logic          r_e,
   input  logic [18:0]   r_vppn,
   input  logic [5:0]    r_ps,
   input  logic [9:0]    r_asid,
   input  logic          r_g,
   input  logic [26:0]   r_lo0,
   input  logic [26:0]   r_lo1
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_FILL = 3'd3, OP_INV = 3'd4;

   state_t        state;
   logic [2:0]    op_q;
   logic          err_q;
   logic [IW-1:0] fill_cnt;
   logic          is_srch, is_wrf, inv_ok, bad, rd_hit;

   assign op_ready    = (state == IDLE);
   assign s1_va_bit12 = 1'b0;
   assign is_srch     = (op_code == OP_SRCH);
   assign is_wrf      = (op_code == OP_WR) || (op_code == OP_FILL);
   assign inv_ok      = (op_code == OP_INV) && (inv_op <= 5'd6);
   assign bad         = (op_code > OP_INV) || ((op_code == OP_INV) && (inv_op > 5'd6));
   assign rd_hit      = (op_q == OP_RD) && r_e;

   // sequencer: latch request and drive TLB ports at accept, capture results leaving EXEC, pulse done in RESP
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         fill_cnt     <= '0;
         op_q         <= '0;
         err_q        <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         wb_srch      <= 1'b0;
         wb_rd        <= 1'b0;
         wb_index     <= '0;
         wb_ne        <= 1'b0;
         wb_ps        <= '0;
         wb_vppn      <= '0;
         wb_asid      <= '0;
         wb_elo0      <= '0;
         wb_elo1      <= '0;
         s1_sel       <= 1'b0;
         s1_vppn      <= '0;
         s1_asid      <= '0;
         invtlb_valid <= 1'b0;
         invtlb_op    <= '0;
         we           <= 1'b0;
         w_index      <= '0;
         w_e          <= 1'b0;
         w_vppn       <= '0;
         w_ps         <= '0;
         w_asid       <= '0;
         w_g          <= 1'b0;
         w_lo0        <= '0;
         w_lo1        <= '0;
         r_index      <= '0;
      end else begin
         fill_cnt <= fill_cnt + 1'b1;
         case (state)
            IDLE: if (op_valid) begin
               state        <= EXEC;
               op_q         <= op_code;
               err_q        <= bad;
               s1_sel       <= is_srch | inv_ok;
               s1_vppn      <= is_srch ? csr_vppn : inv_vppn;
               s1_asid      <= is_srch ? csr_asid : inv_asid;
               invtlb_valid <= inv_ok;
               invtlb_op    <= inv_op;
               we           <= is_wrf;
               w_index      <= (op_code == OP_FILL) ? fill_cnt : csr_index;
               w_e          <= csr_tlbr | ~csr_ne;
               w_vppn       <= csr_vppn;
               w_ps         <= csr_ps;
               w_asid       <= csr_asid;
               w_g          <= csr_elo0[6] & csr_elo1[6];
               w_lo0        <= csr_elo0;
               w_lo1        <= csr_elo1;
               r_index      <= csr_index;
            end
            EXEC: begin
               state        <= RESP;
               s1_sel       <= 1'b0;
               invtlb_valid <= 1'b0;
               we           <= 1'b0;
               done         <= 1'b1;
               err          <= err_q;
               wb_srch      <= (op_q == OP_SRCH);
               wb_rd        <= (op_q == OP_RD);
               wb_index     <= ((op_q == OP_SRCH) && s1_found) ? s1_index : csr_index;
               wb_ne        <= (op_q == OP_SRCH) ? ~s1_found : ((op_q == OP_RD) && !r_e);
               wb_ps        <= rd_hit ? r_ps : '0;
               wb_vppn      <= rd_hit ? r_vppn : '0;
               wb_asid      <= rd_hit ? r_asid : '0;
               wb_elo0      <= rd_hit ? {r_lo0[26:7], r_g, r_lo0[5:0]} : '0;
               wb_elo1      <= rd_hit ? {r_lo1[26:7], r_g, r_lo1[5:0]} : '0;
            end
            default: begin
               state   <= IDLE;
               done    <= 1'b0;
               err     <= 1'b0;
               wb_srch <= 1'b0;
               wb_rd   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: drives tlb_ctrl against a behavioural TLB and checks results against a predicted TLB image
module tb_tlb_ctrl;
   localparam int N = 16;
   localparam int IW = 4;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [26:0] lo0;
      logic [26:0] lo1;
   } ent_t;

   logic clk, resetn, clr;
   logic op_valid, op_ready;
   logic [2:0] op_code;
   logic [4:0] inv_op;
   logic [9:0] inv_asid;
   logic [18:0] inv_vppn;
   logic [IW-1:0] csr_index;
   logic [5:0] csr_ps;
   logic csr_ne;
   logic [18:0] csr_vppn;
   logic [9:0] csr_asid;
   logic [26:0] csr_elo0, csr_elo1;
   logic csr_tlbr;
   logic done, err, wb_srch, wb_rd;
   logic [IW-1:0] wb_index;
   logic wb_ne;
   logic [5:0] wb_ps;
   logic [18:0] wb_vppn;
   logic [9:0] wb_asid;
   logic [26:0] wb_elo0, wb_elo1;
   logic s1_sel, s1_va_bit12, s1_found;
   logic [18:0] s1_vppn;
   logic [9:0] s1_asid;
   logic [IW-1:0] s1_index;
   logic invtlb_valid;
   logic [4:0] invtlb_op;
   logic we, w_e, w_g;
   logic [IW-1:0] w_index, r_index;
   logic [18:0] w_vppn;
   logic [5:0] w_ps;
   logic [9:0] w_asid;
   logic [26:0] w_lo0, w_lo1;
   logic r_e, r_g;
   logic [18:0] r_vppn;
   logic [5:0] r_ps;
   logic [9:0] r_asid;
   logic [26:0] r_lo0, r_lo1;

   ent_t env[N];
   ent_t mdl[N];
   int edges;
   int tot = 0;
   int bad = 0;

   int o_lat, o_we_n, o_inv_n, o_sel_n, o_fill;
   logic [IW-1:0] o_widx, o_idx;
   logic o_we_e, o_wg, o_inv_sel, o_err, o_srch, o_rd, o_ne;
   logic [4:0] o_invop;
   logic [5:0] o_ps;
   logic [18:0] o_vppn;
   logic [9:0] o_asid;
   logic [26:0] o_lo0, o_lo1;

   tlb_ctrl #(.TLBNUM(N)) dut (
      .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
      .csr_index(csr_index), .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_vppn(csr_vppn), .csr_asid(csr_asid),
      .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_tlbr(csr_tlbr),
      .done(done), .err(err), .wb_srch(wb_srch), .wb_rd(wb_rd), .wb_index(wb_index), .wb_ne(wb_ne),
      .wb_ps(wb_ps), .wb_vppn(wb_vppn), .wb_asid(wb_asid), .wb_elo0(wb_elo0), .wb_elo1(wb_elo1),
      .s1_sel(s1_sel), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index), .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
      .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g),
      .w_lo0(w_lo0), .w_lo1(w_lo1), .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps),
      .r_asid(r_asid), .r_g(r_g), .r_lo0(r_lo0), .r_lo1(r_lo1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic vm(ent_t t, logic [18:0] v);
      return (t.ps == 6'd21) ? (t.vppn[18:9] == v[18:9]) : (t.vppn == v);
   endfunction

   function automatic logic hit(ent_t t, logic [18:0] v, logic [9:0] a);
      return t.e && (t.g || t.asid == a) && vm(t, v);
   endfunction

   function automatic logic kill(ent_t t, int op, logic [9:0] a, logic [18:0] v);
      case (op)
         0, 1: return 1'b1;
         2: return t.g;
         3: return !t.g;
         4: return !t.g && t.asid == a;
         5: return !t.g && t.asid == a && vm(t, v);
         6: return (t.g || t.asid == a) && vm(t, v);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int msearch(logic [18:0] v, logic [9:0] a);
      for (int i = 0; i < N; i++) if (hit(mdl[i], v, a)) return i;
      return -1;
   endfunction

   // behavioural TLB array; the top-level split drops the g bit out of the lo buses
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < N; i++) env[i] <= '0;
      end else begin
         if (we) env[w_index] <= '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                                   lo0: w_lo0 & ~27'h40, lo1: w_lo1 & ~27'h40};
         if (invtlb_valid)
            for (int i = 0; i < N; i++)
               if (kill(env[i], int'(invtlb_op), s1_asid, s1_vppn)) env[i].e <= 1'b0;
      end
   end

   always_comb begin
      s1_found = 1'b0;
      s1_index = '0;
      for (int i = N - 1; i >= 0; i--)
         if (hit(env[i], s1_vppn, s1_asid)) begin
            s1_found = 1'b1;
            s1_index = IW'(i);
         end
   end

   assign r_e    = env[r_index].e;
   assign r_vppn = env[r_index].vppn;
   assign r_ps   = env[r_index].ps;
   assign r_asid = env[r_index].asid;
   assign r_g    = env[r_index].g;
   assign r_lo0  = env[r_index].lo0;
   assign r_lo1  = env[r_index].lo1;

   always @(posedge clk or negedge resetn)
      if (!resetn) edges <= 0;
      else edges <= edges + 1;

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic do_op(input logic [2:0] code, input bit wait_first);
      int k;
      op_code = code;
      if (wait_first) @(negedge clk);
      k = 0;
      while (!op_ready && k < 10) begin
         @(negedge clk);
         k++;
      end
      o_fill = edges % N;
      op_valid = 1'b1;
      @(posedge clk);
      #1 op_valid = 1'b0;
      o_lat = -1; o_we_n = 0; o_inv_n = 0; o_sel_n = 0;
      o_widx = '0; o_we_e = 1'b0; o_wg = 1'b0; o_inv_sel = 1'b0; o_invop = '0;
      for (int i = 1; i <= 5 && o_lat < 0; i++) begin
         @(negedge clk);
         if (we) begin
            o_we_n++; o_widx = w_index; o_we_e = w_e; o_wg = w_g;
         end
         if (invtlb_valid) begin
            o_inv_n++; o_invop = invtlb_op; o_inv_sel = s1_sel;
         end
         if (s1_sel) o_sel_n++;
         if (done) begin
            o_lat = i; o_err = err; o_srch = wb_srch; o_rd = wb_rd; o_ne = wb_ne; o_idx = wb_index;
            o_ps = wb_ps; o_vppn = wb_vppn; o_asid = wb_asid; o_lo0 = wb_elo0; o_lo1 = wb_elo1;
         end
      end
   endtask

   task automatic mdl_apply(input logic [2:0] c);
      int ix;
      if (c == 3'd2 || c == 3'd3) begin
         ix = (c == 3'd3) ? o_fill : int'(csr_index);
         mdl[ix] = '{e: csr_tlbr | ~csr_ne, vppn: csr_vppn, ps: csr_ps, asid: csr_asid,
                     g: csr_elo0[6] & csr_elo1[6], lo0: csr_elo0, lo1: csr_elo1};
      end
      if (c == 3'd4 && inv_op <= 5'd6)
         for (int i = 0; i < N; i++)
            if (kill(mdl[i], int'(inv_op), inv_asid, inv_vppn)) mdl[i].e = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      tot++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
      tot++;
      if ({done, err, wb_srch, wb_rd, we, invtlb_valid, s1_sel, wb_ne, wb_index} !== '0) begin
         bad++; $display("FAIL reset_outputs got=%b exp=0", {done, err, wb_srch, wb_rd, we, invtlb_valid, s1_sel, wb_ne, wb_index});
      end
      resetn = 1'b1;
      clr = 1'b0;
   endtask

   task automatic test_round_trip;
      csr_index = 4'd5; csr_vppn = 19'h1234; csr_asid = 10'd7; csr_ps = 6'd12; csr_ne = 1'b0; csr_tlbr = 1'b0;
      csr_elo0 = {20'h12345, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1};
      csr_elo1 = {20'h6789a, 1'b1, 2'd1, 2'd3, 1'b0, 1'b1};
      do_op(3'd2, 1'b1);
      mdl_apply(3'd2);
      tot++; if (o_lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", o_lat); end
      tot++; if (o_we_n !== 1) begin bad++; $display("FAIL wr_we_pulses got=%0d exp=1", o_we_n); end
      tot++; if ({o_widx, o_we_e, o_wg} !== {4'd5, 1'b1, 1'b1}) begin
         bad++; $display("FAIL wr_fields got=%h/%b/%b exp=5/1/1", o_widx, o_we_e, o_wg);
      end
      csr_asid = 10'd9;
      do_op(3'd0, 1'b1);
      tot++; if ({o_srch, o_rd, o_ne, o_idx} !== {1'b1, 1'b0, 1'b0, 4'd5}) begin
         bad++; $display("FAIL srch_hit got=%b%b%b/%0d exp=100/5", o_srch, o_rd, o_ne, o_idx);
      end
      do_op(3'd1, 1'b1);
      tot++; if ({o_rd, o_ne, o_vppn, o_ps} !== {1'b1, 1'b0, 19'h1234, 6'd12}) begin
         bad++; $display("FAIL rd_entry got=%b%b/%h/%0d exp=10/1234/12", o_rd, o_ne, o_vppn, o_ps);
      end
      tot++; if ({o_lo0, o_lo1} !== {csr_elo0, csr_elo1}) begin
         bad++; $display("FAIL rd_elo got=%h/%h exp=%h/%h", o_lo0, o_lo1, csr_elo0, csr_elo1);
      end
   endtask

   task automatic test_srch_miss;
      csr_index = 4'd11; csr_vppn = 19'h7ffff;
      do_op(3'd0, 1'b1);
      tot++; if ({o_srch, o_ne, o_idx} !== {1'b1, 1'b1, 4'd11}) begin
         bad++; $display("FAIL srch_miss got=%b%b/%0d exp=11/11", o_srch, o_ne, o_idx);
      end
   endtask

   task automatic test_rd_invalid;
      inv_op = 5'd0;
      do_op(3'd4, 1'b1);
      mdl_apply(3'd4);
      tot++; if ({o_inv_n, o_err} !== {32'd1, 1'b0}) begin
         bad++; $display("FAIL inv0_strobe got=%0d/%b exp=1/0", o_inv_n, o_err);
      end
      csr_index = 4'd5;
      do_op(3'd1, 1'b1);
      tot++; if ({o_rd, o_ne} !== 2'b11) begin bad++; $display("FAIL rd_invalid_ne got=%b%b exp=11", o_rd, o_ne); end
      tot++; if ({o_vppn, o_asid, o_ps, o_lo0, o_lo1} !== '0) begin
         bad++; $display("FAIL rd_invalid_zero got=%h/%h/%h/%h/%h exp=0", o_vppn, o_asid, o_ps, o_lo0, o_lo1);
      end
   endtask

   task automatic test_invtlb;
      csr_index = 4'd3; csr_vppn = 19'h1234; csr_asid = 10'd7; csr_ps = 6'd12; csr_ne = 1'b0;
      csr_elo0 = 27'h0abcd03; csr_elo1 = 27'h0123403;
      do_op(3'd2, 1'b1);
      mdl_apply(3'd2);
      do_op(3'd0, 1'b1);
      tot++; if ({o_ne, o_idx} !== {1'b0, 4'd3}) begin bad++; $display("FAIL inv_pre_hit got=%b/%0d exp=0/3", o_ne, o_idx); end
      inv_op = 5'd5; inv_asid = 10'd7; inv_vppn = 19'h1234;
      do_op(3'd4, 1'b1);
      mdl_apply(3'd4);
      tot++; if ({o_inv_n, o_inv_sel, o_invop, o_we_n} !== {32'd1, 1'b1, 5'd5, 32'd0}) begin
         bad++; $display("FAIL inv5_strobe got=%0d/%b/%0d/%0d exp=1/1/5/0", o_inv_n, o_inv_sel, o_invop, o_we_n);
      end
      do_op(3'd0, 1'b1);
      tot++; if ({o_ne, o_idx} !== {1'b1, 4'd3}) begin bad++; $display("FAIL inv_post_miss got=%b/%0d exp=1/3", o_ne, o_idx); end
   endtask

   task automatic test_inv_err;
      inv_op = 5'd7;
      do_op(3'd4, 1'b1);
      tot++; if ({o_lat, o_err, o_inv_n, o_we_n, o_sel_n} !== {32'd2, 1'b1, 32'd0, 32'd0, 32'd0}) begin
         bad++; $display("FAIL inv7_err got=%0d/%b/%0d/%0d/%0d exp=2/1/0/0/0", o_lat, o_err, o_inv_n, o_we_n, o_sel_n);
      end
      inv_op = 5'd0;
      do_op(3'd6, 1'b1);
      tot++; if ({o_lat, o_err, o_inv_n, o_we_n, o_sel_n, o_srch, o_rd} !== {32'd2, 1'b1, 32'd0, 32'd0, 32'd0, 2'b00}) begin
         bad++; $display("FAIL illegal_op got=%0d/%b/%0d/%0d/%0d exp=2/1/0/0/0", o_lat, o_err, o_inv_n, o_we_n, o_sel_n);
      end
   endtask

   task automatic test_reset_mid;
      int k;
      csr_index = 4'd9; csr_vppn = 19'h5555; csr_asid = 10'd3; csr_ps = 6'd12; csr_ne = 1'b0; csr_tlbr = 1'b0;
      @(negedge clk);
      k = 0;
      while (!op_ready && k < 10) begin @(negedge clk); k++; end
      op_code = 3'd2; op_valid = 1'b1;
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(negedge clk);
      tot++; if (we !== 1'b1) begin bad++; $display("FAIL mid_we_before got=%b exp=1", we); end
      #1 resetn = 1'b0;
      #1;
      tot++; if (we !== 1'b0) begin bad++; $display("FAIL mid_we_drop got=%b exp=0", we); end
      tot++; if ({op_ready, done, s1_sel, invtlb_valid} !== 4'b1000) begin
         bad++; $display("FAIL mid_outputs got=%b exp=1000", {op_ready, done, s1_sel, invtlb_valid});
      end
      repeat (2) begin
         @(negedge clk);
         tot++; if (done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b exp=0", done); end
      end
      csr_tlbr = 1'b1; csr_ne = 1'b1;
      resetn = 1'b1;
      do_op(3'd3, 1'b0);
      mdl_apply(3'd3);
      tot++; if ({o_lat, o_widx, o_we_e} !== {32'd2, 4'd0, 1'b1}) begin
         bad++; $display("FAIL fill_after_reset got=%0d/%0d/%b exp=2/0/1", o_lat, o_widx, o_we_e);
      end
      csr_tlbr = 1'b0; csr_index = 4'd9;
      do_op(3'd1, 1'b1);
      tot++; if (o_ne !== 1'b1) begin bad++; $display("FAIL dropped_wr got=%b exp=1", o_ne); end
   endtask

   task automatic test_fill;
      csr_vppn = 19'h0777; csr_asid = 10'd2; csr_tlbr = 1'b1; csr_ne = 1'b1;
      do_op(3'd3, 1'b1);
      mdl_apply(3'd3);
      tot++; if ({o_we_n, o_widx, o_we_e} !== {32'd1, 4'(o_fill), 1'b1}) begin
         bad++; $display("FAIL fill_tlbr got=%0d/%0d/%b exp=1/%0d/1", o_we_n, o_widx, o_we_e, o_fill);
      end
      csr_tlbr = 1'b0;
      do_op(3'd3, 1'b1);
      mdl_apply(3'd3);
      tot++; if ({o_widx, o_we_e} !== {4'(o_fill), 1'b0}) begin
         bad++; $display("FAIL fill_ne got=%0d/%b exp=%0d/0", o_widx, o_we_e, o_fill);
      end
   endtask

   task automatic test_back_to_back;
      int got, f0, k;
      logic [IW-1:0] ix0, ix1;
      csr_tlbr = 1'b0; csr_ne = 1'b0; csr_vppn = 19'h0aaaa; csr_asid = 10'd4;
      got = 0; ix0 = '0; ix1 = '0;
      @(negedge clk);
      k = 0;
      while (!op_ready && k < 10) begin @(negedge clk); k++; end
      f0 = edges;
      op_code = 3'd3; op_valid = 1'b1;
      for (int i = 0; i < 12 && got < 2; i++) begin
         @(negedge clk);
         if (we) begin
            if (got == 0) ix0 = w_index; else ix1 = w_index;
            got++;
         end
      end
      op_valid = 1'b0;
      @(negedge clk);
      tot++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
      tot++; if (got !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", got); end
      tot++; if ({ix0, ix1} !== {4'(f0), 4'(f0 + 3)}) begin
         bad++; $display("FAIL b2b_index got=%0d/%0d exp=%0d/%0d", ix0, ix1, f0 % N, (f0 + 3) % N);
      end
      tot++; if (4'(ix1 - ix0) !== 4'd3) begin bad++; $display("FAIL b2b_gap got=%0d exp=3", 4'(ix1 - ix0)); end
      o_fill = f0 % N;
      mdl_apply(3'd3);
      o_fill = (f0 + 3) % N;
      mdl_apply(3'd3);
   endtask

   task automatic test_random;
      int r, s;
      logic [2:0] c;
      logic exp_err;
      ent_t t;
      logic [93:0] exp_rd;
      for (int n = 0; n < 80; n++) begin
         csr_index = IW'($urandom_range(0, N - 1));
         csr_vppn = 19'($urandom_range(0, 3) * 512 + $urandom_range(0, 1));
         csr_asid = 10'($urandom_range(0, 2));
         csr_ps = ($urandom_range(0, 1) == 1) ? 6'd21 : 6'd12;
         csr_ne = 1'($urandom_range(0, 1));
         csr_tlbr = ($urandom_range(0, 5) == 0);
         csr_elo0 = 27'($urandom);
         csr_elo1 = 27'($urandom);
         inv_op = 5'($urandom_range(0, 7));
         inv_asid = 10'($urandom_range(0, 2));
         inv_vppn = 19'($urandom_range(0, 3) * 512 + $urandom_range(0, 1));
         r = $urandom_range(0, 11);
         c = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 8) ? 3'd2 : (r < 9) ? 3'd3 : (r < 11) ? 3'd4 : 3'($urandom_range(5, 7));
         s = msearch(csr_vppn, csr_asid);
         t = mdl[csr_index];
         exp_err = (c > 3'd4) || (c == 3'd4 && inv_op > 5'd6);
         exp_rd = t.e ? {1'b0, t.vppn, t.ps, t.asid, t.lo0[26:7], t.g, t.lo0[5:0], t.lo1[26:7], t.g, t.lo1[5:0], csr_index}
                      : {1'b1, 89'd0, csr_index};
         do_op(c, 1'b1);
         tot++; if ({o_lat, o_err} !== {32'd2, exp_err}) begin
            bad++; $display("FAIL rnd_done op=%0d got=%0d/%b exp=2/%b", c, o_lat, o_err, exp_err);
         end
         tot++; if ({o_srch, o_rd} !== {c == 3'd0, c == 3'd1}) begin
            bad++; $display("FAIL rnd_wb_en op=%0d got=%b%b", c, o_srch, o_rd);
         end
         tot++; if ({o_we_n, o_inv_n} !== {32'(c == 3'd2 || c == 3'd3), 32'(c == 3'd4 && !exp_err)}) begin
            bad++; $display("FAIL rnd_strobes op=%0d got=%0d/%0d", c, o_we_n, o_inv_n);
         end
         if (c == 3'd0) begin
            tot++; if ({o_ne, o_idx} !== {s < 0, (s < 0) ? csr_index : IW'(s)}) begin
               bad++; $display("FAIL rnd_srch got=%b/%0d exp=%b/%0d", o_ne, o_idx, s < 0, (s < 0) ? int'(csr_index) : s);
            end
         end
         if (c == 3'd1) begin
            tot++; if ({o_ne, o_vppn, o_ps, o_asid, o_lo0, o_lo1, o_idx} !== exp_rd) begin
               bad++; $display("FAIL rnd_rd got=%h exp=%h", {o_ne, o_vppn, o_ps, o_asid, o_lo0, o_lo1, o_idx}, exp_rd);
            end
         end
         if (c == 3'd2 || c == 3'd3) begin
            tot++;
            if ({o_widx, o_we_e, o_wg} !== {(c == 3'd3) ? IW'(o_fill) : csr_index, csr_tlbr | ~csr_ne, csr_elo0[6] & csr_elo1[6]}) begin
               bad++; $display("FAIL rnd_write op=%0d got=%0d/%b/%b", c, o_widx, o_we_e, o_wg);
            end
         end
         if (c == 3'd4 && !exp_err) begin
            tot++; if ({o_invop, o_inv_sel} !== {inv_op, 1'b1}) begin
               bad++; $display("FAIL rnd_inv got=%0d/%b exp=%0d/1", o_invop, o_inv_sel, inv_op);
            end
         end
         mdl_apply(c);
      end
   endtask

   initial begin
      resetn = 1'b0; clr = 1'b1; op_valid = 1'b0; op_code = '0;
      inv_op = '0; inv_asid = '0; inv_vppn = '0;
      csr_index = '0; csr_ps = '0; csr_ne = 1'b0; csr_vppn = '0; csr_asid = '0;
      csr_elo0 = '0; csr_elo1 = '0; csr_tlbr = 1'b0;
      for (int i = 0; i < N; i++) mdl[i] = '0;
      test_reset;
      test_round_trip;
      test_srch_miss;
      test_rd_invalid;
      test_invtlb;
      test_inv_err;
      test_reset_mid;
      test_fill;
      test_back_to_back;
      test_random;
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule
